axi_master_read_channel: RTL and testbench
==========================================

Name: axi_master_read_channel

Overview:
- AXI read initiator: the master end of the AR and R channels.
- Accepts one burst-read request at a time from a local client (cache refill or instruction fetch unit), issues the AR beat, and streams the returned R beats to the client with backpressure.
- Reports a completion pulse with the worst response code and a beat-count error flag.
- Pairs with the team's AXI slave read channel on the memory side.

Parameters:
ADDR_WIDTH, 32, address width of req_addr and ARADDR
READ_CHANNEL_WIDTH, 32, data width per beat (RDATA, rd_data)
READ_BURST_LEN, 8, width of ARLEN and req_len; burst has len+1 beats

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  client burst request valid
req_ready  output  1  block can accept request
req_addr  input  ADDR_WIDTH  burst start address
req_len  input  READ_BURST_LEN  beats minus one
ARVALID  output  1  read address valid
ARREADY  input  1  slave accepts address
ARADDR  output  ADDR_WIDTH  latched req_addr
ARLEN  output  READ_BURST_LEN  latched req_len
ARSIZE  output  3  fixed 3'b010 (4 bytes)
ARBURST  output  2  fixed 2'b01 (INCR)
RVALID  input  1  read data valid
RDATA  input  READ_CHANNEL_WIDTH  read data
RLAST  input  1  last beat of burst
RRESP  input  2  beat response
RREADY  output  1  master accepts beat
rd_valid  output  1  beat to client valid
rd_ready  input  1  client accepts beat
rd_data  output  READ_CHANNEL_WIDTH  beat data
rd_last  output  1  beat carries RLAST
done  output  1  one-cycle burst-complete pulse
done_resp  output  2  max RRESP over burst, valid with done
done_err  output  1  beat count != len+1, valid with done

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (rst high, asynchronous) sets:
  - state IDLE;
  - r_addr, r_len, beat_cnt, resp_max and err to 0;
  - ARVALID, RREADY, rd_valid, done, done_resp and done_err to 0;
  - req_ready to 0 while rst is high, 1 after release.
- States are IDLE, ADDR, DATA and DONE. ARVALID, RREADY, req_ready and done are decoded from registered state only.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_addr into r_addr and req_len into r_len; clear beat_cnt, resp_max and err; go to ADDR.
- ADDR:
  - ARVALID=1; ARADDR=r_addr; ARLEN=r_len; ARSIZE=3'b010; ARBURST=2'b01.
  - These fields stay stable until ARREADY; ARVALID never drops before handshake.
  - On ARVALID&&ARREADY go to DATA. Earliest first R beat is the cycle after this handshake.
  - ARADDR and ARLEN hold r_addr/r_len in all states; they are only meaningful while ARVALID=1.
- DATA:
  - Pass-through with no buffering: RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST. This path is combinational, with zero latency.
  - Beat handshake is RVALID&&RREADY. On each beat:
    - beat_cnt increments, saturating at 2^READ_BURST_LEN;
    - resp_max takes the larger of resp_max and RRESP (unsigned compare).
  - Burst terminates only on a handshake with RLAST=1, then goes to DONE.
  - Early RLAST (beat_cnt!=r_len on that beat) sets err.
  - If beat beat_cnt==r_len handshakes without RLAST, err is set and the block keeps accepting beats until RLAST.
  - RVALID while RREADY=0 is not a beat; counters hold.
- DONE:
  - done=1 for exactly one cycle; done_resp=resp_max; done_err=err.
  - req_ready=0 in this state; the next state is IDLE.
  - Back-to-back requests: minimum 4 cycles from accept to next accept (IDLE, ADDR, DATA with 1 beat, DONE).
- R beats arriving in IDLE/ADDR/DONE: RREADY=0 and rd_valid=0; they are ignored.
- Reset mid-burst: ARVALID/RREADY drop asynchronously and the burst is abandoned; no done pulse. This is acceptable because reset is system-wide.
- Width rules:
  - beat_cnt is READ_BURST_LEN+1 bits.
  - req_len=2^READ_BURST_LEN-1 (255) is a legal 256-beat burst.
- Only one outstanding burst; no AR pipelining and no ID signals.

Test Plan:
- Single-beat read: req_addr=0x100, req_len=0, ARREADY same cycle, one R beat with RLAST=1 and RRESP=0 -> ARLEN=0, ARSIZE=3'b010, ARBURST=2'b01, rd_valid for 1 cycle, done=1 one cycle, done_resp=0, done_err=0.
- 8-beat burst, slave AR stall 3 cycles: req_len=7, ARREADY low 3 cycles -> ARVALID/ARADDR=0x200 stable for 4 cycles; data 0..7 forwarded in order; rd_last on beat 7 only; done_err=0.
- Client backpressure: rd_ready toggles 1,0,1,0 during 4-beat burst -> RREADY mirrors rd_ready; no beat duplicated or lost; done after 4th handshake.
- Response tracking: 4 beats with RRESP 0,0,0,2 -> done_resp=2'b10, done_err=0.
- Length mismatch: req_len=3, RLAST on beat 2 -> done after beat 2, done_err=1. Separately, req_len=1 with RLAST on beat 4 -> all 4 beats forwarded, done_err=1.
- Async reset in DATA after 2 beats -> ARVALID, RREADY and rd_valid go 0 immediately; no done pulse; after release req_ready=1 and a new burst completes normally.

Source files
------------

// File: rtl/axi_master_read_channel.sv
// -----------------------------------------------------------------------------
// axi_master_read_channel
//
// Master end of the AXI AR and R channels. Takes one burst-read request at a
// time from a local client, issues the AR beat, and passes the returned R beats
// through to the client. The client's backpressure reaches the slave unchanged
// because nothing is buffered. When the burst ends, a one-cycle completion pulse
// reports the worst response seen and whether the beat count was wrong.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          client burst request handshake
//   req_addr, req_len            burst start address, beats minus one
//   ARVALID/ARREADY, ARADDR,     AXI read address channel
//   ARLEN, ARSIZE, ARBURST
//   RVALID/RREADY, RDATA,        AXI read data channel
//   RLAST, RRESP
//   rd_valid/rd_ready, rd_data,  beat stream to the client
//   rd_last
//   done, done_resp, done_err    burst completion pulse, worst RRESP, count error
// -----------------------------------------------------------------------------
module axi_master_read_channel #(
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 32,
  parameter int READ_BURST_LEN     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  // client request
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [READ_BURST_LEN-1:0]     req_len,
  // AR channel
  output logic                          ARVALID,
  input  logic                          ARREADY,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  output logic [READ_BURST_LEN-1:0]     ARLEN,
  output logic [2:0]                    ARSIZE,
  output logic [1:0]                    ARBURST,
  // R channel
  input  logic                          RVALID,
  input  logic [READ_CHANNEL_WIDTH-1:0] RDATA,
  input  logic                          RLAST,
  input  logic [1:0]                    RRESP,
  output logic                          RREADY,
  // client beat stream
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [READ_CHANNEL_WIDTH-1:0] rd_data,
  output logic                          rd_last,
  // completion
  output logic                          done,
  output logic [1:0]                    done_resp,
  output logic                          done_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     r_addr_q;
  logic [READ_BURST_LEN-1:0] r_len_q;
  // One extra bit so a full 2^READ_BURST_LEN-beat burst can be counted.
  logic [READ_BURST_LEN:0]   beat_cnt_q, beat_cnt_d;
  logic [1:0]                resp_max_q, resp_max_d;
  logic                      err_q;

  logic beat_hs;  // R handshake that counts as a beat
  logic len_hit;  // current beat is the one ARLEN says should be last

  // NOTE: every signal written here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    beat_hs    = (state_q == DATA) && RVALID && rd_ready;
    len_hit    = (beat_cnt_q == {1'b0, r_len_q});
    beat_cnt_d = beat_cnt_q;
    // Stop counting once the MSB is set so an overlong burst cannot wrap the
    // counter back into a range that looks like a matching length.
    if (!beat_cnt_q[READ_BURST_LEN]) begin
      beat_cnt_d = beat_cnt_q + (READ_BURST_LEN+1)'(1);
    end
    resp_max_d = (RRESP > resp_max_q) ? RRESP : resp_max_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      beat_cnt_q <= '0;
      resp_max_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            r_addr_q   <= req_addr;
            r_len_q    <= req_len;
            beat_cnt_q <= '0;
            resp_max_q <= '0;
            err_q      <= 1'b0;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) state_q <= DATA;
        end
        DATA: begin
          if (beat_hs) begin
            beat_cnt_q <= beat_cnt_d;
            resp_max_q <= resp_max_d;
            if (RLAST) begin
              // The burst ends on RLAST no matter what the count says.
              // A mismatch is reported, not enforced.
              if (!len_hit) err_q <= 1'b1;
              state_q <= DONE;
            end else if (len_hit) begin
              // The slave overran ARLEN. Keep draining until it sends RLAST.
              err_q <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Control outputs are decoded from the registered state. Reset forces IDLE
  // asynchronously, so ARVALID and RREADY drop as soon as rst rises.
  // req_ready is additionally gated by rst so that it stays low during reset.
  assign req_ready = (state_q == IDLE) && !rst;
  assign ARVALID   = (state_q == ADDR);
  assign ARADDR    = r_addr_q;
  assign ARLEN     = r_len_q;
  assign ARSIZE    = 3'b010;
  assign ARBURST   = 2'b01;

  // The data path is a zero-latency pass-through, enabled only in DATA.
  assign RREADY    = (state_q == DATA) && rd_ready;
  assign rd_valid  = (state_q == DATA) && RVALID;
  assign rd_data   = RDATA;
  assign rd_last   = RLAST;

  assign done      = (state_q == DONE);
  assign done_resp = (state_q == DONE) ? resp_max_q : 2'b00;
  assign done_err  = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_axi_master_read_channel.sv
// -----------------------------------------------------------------------------
// tb_axi_master_read_channel
//
// Randomized self-checking bench. Each burst is described as a client request
// (address, length) plus the list of beats the slave will return (data,
// response, count). The expected results come from that list: every beat
// forwarded in order, rd_last only on the final beat, done_resp equal to the
// maximum response, and done_err set when the count differs from len+1.
// -----------------------------------------------------------------------------
module tb_axi_master_read_channel;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          ARVALID;
  logic          ARREADY;
  logic [AW-1:0] ARADDR;
  logic [LW-1:0] ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          RVALID;
  logic [DW-1:0] RDATA;
  logic          RLAST;
  logic [1:0]    RRESP;
  logic          RREADY;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done;
  logic [1:0]    done_resp;
  logic          done_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Beats the slave returns for the current burst.
  logic [DW-1:0] exp_data [0:299];
  logic [1:0]    exp_resp [0:299];

  axi_master_read_channel #(
    .ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
    .RREADY(RREADY),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_err(done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Runs one burst. Inputs are driven at the falling edge. Outputs are sampled
  // 1 time unit later, which is well before the next rising edge.
  // rr_mode: 0 = rd_ready always high, 1 = toggles 1,0,1,0..., 2 = random.
  // abort_at >= 0: assert reset once that many beats have been transferred.
  task automatic burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       input int nbeats, input int ar_stall, input int rr_mode,
                       input bit rv_rand, input int abort_at);
    int       i;
    int       cyc;
    logic [1:0] mx;
    bit       exp_err;
    mx = 2'b00;
    for (int k = 0; k < nbeats; k++) if (exp_resp[k] > mx) mx = exp_resp[k];
    exp_err = (nbeats != int'(len) + 1);

    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_len = len;
    #1 check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request inputs so the bench can see that the DUT latched them.
    req_valid = 1'b0; req_addr = $urandom; req_len = LW'($urandom);

    for (int s = 0; s <= ar_stall; s++) begin
      ARREADY = (s == ar_stall);
      // R-channel noise here must be ignored.
      RVALID = 1'($urandom_range(0, 1)); RDATA = $urandom; RLAST = 1'b1;
      rd_ready = 1'b1;
      #1;
      check("arvalid", ARVALID, 1);
      check("araddr", ARADDR, addr);
      check("arlen", ARLEN, len);
      check("arsize", ARSIZE, 3'b010);
      check("arburst", ARBURST, 2'b01);
      check("rready_in_addr", RREADY, 0);
      check("rd_valid_in_addr", rd_valid, 0);
      @(posedge clk);
      @(negedge clk);
    end
    ARREADY = 1'b0;

    i = 0; cyc = 0;
    while (i < nbeats && cyc < 1000) begin
      if (i == abort_at) begin
        RVALID = 1'b1; rd_ready = 1'b1; RDATA = exp_data[i]; RLAST = 1'b0;
        #1 check("rready_pre_reset", RREADY, 1);
        rst = 1'b1;
        #1;
        check("arvalid_in_reset", ARVALID, 0);
        check("rready_in_reset", RREADY, 0);
        check("rd_valid_in_reset", rd_valid, 0);
        check("req_ready_in_reset", req_ready, 0);
        @(posedge clk);
        #1 check("no_done_after_reset", done, 0);
        @(negedge clk);
        rst = 1'b0; RVALID = 1'b0;
        #1 check("req_ready_after_reset", req_ready, 1);
        return;
      end
      RVALID = rv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      RDATA  = exp_data[i];
      RRESP  = exp_resp[i];
      RLAST  = (i == nbeats - 1);
      case (rr_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("rready_mirror", RREADY, rd_ready);
      check("rd_valid_pass", rd_valid, RVALID);
      check("no_early_done", done, 0);
      if (RVALID && rd_ready) begin
        check("rd_data", rd_data, exp_data[i]);
        check("rd_last", rd_last, (i == nbeats - 1));
        i++;
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    check("beats_in_budget", i, nbeats);

    // A stray beat in DONE must not be forwarded.
    RVALID = 1'b1; RLAST = 1'b0; rd_ready = 1'b1;
    #1;
    check("done_pulse", done, 1);
    check("done_resp", done_resp, mx);
    check("done_err", done_err, exp_err);
    check("req_ready_in_done", req_ready, 0);
    check("rd_valid_in_done", rd_valid, 0);
    @(posedge clk);
    @(negedge clk);
    RVALID = 1'b0;
    #1;
    check("done_one_cycle", done, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  initial begin
    int len;
    int nb;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    ARREADY = 1'b0; RVALID = 1'b1; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
    rd_ready = 1'b1;
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_done_resp", done_resp, 0);
    check("rst_done_err", done_err, 0);
    check("rst_araddr", ARADDR, 0);
    @(negedge clk);
    rst = 1'b0; RVALID = 1'b0;
    #1 check("req_ready_released", req_ready, 1);

    // Single-beat read.
    exp_data[0] = 32'hCAFE_0001; exp_resp[0] = 2'b00;
    burst(32'h100, 8'd0, 1, 0, 0, 1'b0, -1);

    // 8-beat burst, AR stalled 3 cycles, data 0..7.
    for (int k = 0; k < 8; k++) begin exp_data[k] = k; exp_resp[k] = 2'b00; end
    burst(32'h200, 8'd7, 8, 3, 0, 1'b0, -1);

    // Client backpressure toggling 1,0,1,0.
    for (int k = 0; k < 4; k++) begin exp_data[k] = $urandom; exp_resp[k] = 2'b00; end
    burst(32'h300, 8'd3, 4, 0, 1, 1'b0, -1);

    // Response tracking 0,0,0,2.
    for (int k = 0; k < 4; k++) begin exp_data[k] = $urandom; exp_resp[k] = 2'b00; end
    exp_resp[3] = 2'b10;
    burst(32'h400, 8'd3, 4, 1, 0, 1'b0, -1);

    // Early RLAST: len 3, RLAST on beat 2.
    for (int k = 0; k < 3; k++) begin exp_data[k] = $urandom; exp_resp[k] = 2'b01; end
    burst(32'h500, 8'd3, 3, 0, 2, 1'b0, -1);

    // Overrun: len 1, RLAST on beat 4.
    for (int k = 0; k < 4; k++) begin exp_data[k] = $urandom; exp_resp[k] = 2'(k); end
    burst(32'h600, 8'd1, 4, 0, 0, 1'b1, -1);

    // Reset in DATA after 2 beats, then a normal burst.
    for (int k = 0; k < 8; k++) begin exp_data[k] = $urandom; exp_resp[k] = 2'b00; end
    burst(32'h700, 8'd7, 8, 0, 0, 1'b0, 2);
    for (int k = 0; k < 2; k++) begin exp_data[k] = $urandom; exp_resp[k] = 2'b01; end
    burst(32'h800, 8'd1, 2, 2, 0, 1'b0, -1);

    // Maximum-length burst: 256 beats.
    for (int k = 0; k < 256; k++) begin
      exp_data[k] = $urandom; exp_resp[k] = (k == 100) ? 2'b11 : 2'b00;
    end
    burst(32'hFFFF_F000, 8'd255, 256, 0, 2, 1'b1, -1);

    // Random bursts, sometimes with a wrong beat count.
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(0, 15);
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : len + 1;
      for (int k = 0; k < nb; k++) begin
        exp_data[k] = $urandom; exp_resp[k] = 2'($urandom_range(0, 3));
      end
      burst($urandom, LW'(len), nb, $urandom_range(0, 3), 2, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
